// File: rtl/uram_event_stream_framer_if.sv
// AXI4-Stream bundle between the event framer and its downstream consumer.
// tuser[0] flags a header word, tuser[1] flags a framing error.
interface uram_event_stream_framer_if #(
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [1:0]        tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, input  tuser, output tready);
endinterface

// File: rtl/uram_event_stream_framer.sv
// Frames the URAM readout word stream into events and buffers it in an FWFT FIFO
// feeding an AXI4-Stream master. Define URAM_FRAMER_HDRCHK_EN to enable header framing checks.
module uram_event_stream_framer #(
  parameter int DATA_W      = 64,
  parameter int HDR_WORDS   = 4,
  parameter int EVENT_WORDS = 4100,
  parameter int FIFO_ADDR_W = 13
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              in_valid_i,
  input  logic              in_header_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              clear_i,
  output logic              space_ok_o,
  output logic              overflow_o,
  output logic              err_o,
  uram_event_stream_framer_if.master m_axis
);

`ifdef URAM_FRAMER_HDRCHK_EN
  localparam bit HDRCHK = 1'b1;
`else
  localparam bit HDRCHK = 1'b0;
`endif

  localparam int DEPTH = 1 << FIFO_ADDR_W;
  localparam int OCC_W = FIFO_ADDR_W + 1;
  localparam int CNT_W = $clog2(EVENT_WORDS);

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(EVENT_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_HDR_LAST = CNT_W'(HDR_WORDS - 1);
  localparam logic [OCC_W-1:0] OCC_FULL     = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE      = OCC_W'(1);
  localparam logic [OCC_W-1:0] SPACE_MIN    = OCC_W'(EVENT_WORDS);
  localparam logic [FIFO_ADDR_W-1:0] PTR_ONE = FIFO_ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_e;

  typedef struct packed {
    logic              err;
    logic              hdr;
    logic              last;
    logic [DATA_W-1:0] data;
  } word_t;

  // Framer state
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_en_q, wr_en_d;
  word_t            wr_word_q, wr_word_d;
  logic             frame_err;
  logic             word_last;

  // FIFO state
  word_t                  mem [DEPTH];
  logic [FIFO_ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]       occ_q, occ_d;
  logic                   fifo_full, fifo_empty;
  logic                   do_wr, do_rd;
  word_t                  head;

  // Flags
  logic space_ok_q, overflow_q, err_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_word_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_word_q <= wr_word_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned and infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_word_d = wr_word_q;
    frame_err = 1'b0;
    word_last = 1'b0;

    if (in_valid_i) begin
      wr_en_d = 1'b1;
      unique case (state_q)
        IDLE: begin
          // Without header checking any word opens an event; with it, stray data is dropped.
          if (in_header_i || !HDRCHK) begin
            state_d = (in_header_i && HDR_WORDS > 1) ? HDR : DATA;
            cnt_d   = CNT_ONE;
          end else begin
            wr_en_d   = 1'b0;
            frame_err = 1'b1;
          end
        end
        HDR: begin
          frame_err = HDRCHK && !in_header_i;
          cnt_d     = cnt_q + CNT_ONE;
          if (cnt_q == CNT_HDR_LAST) begin
            state_d = DATA;
          end
        end
        DATA: begin
          if (HDRCHK && in_header_i) begin
            // A header mid-event means upstream restarted: reopen the event on this word.
            frame_err = 1'b1;
            state_d   = (HDR_WORDS > 1) ? HDR : DATA;
            cnt_d     = CNT_ONE;
          end else if (cnt_q == CNT_LAST) begin
            word_last = 1'b1;
            state_d   = IDLE;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
      wr_word_d = '{err: frame_err, hdr: in_header_i, last: word_last, data: in_data_i};
    end
  end

  // A full FIFO drops the word; the count above has already advanced, so framing stays aligned.
  assign fifo_full  = (occ_q == OCC_FULL);
  assign fifo_empty = (occ_q == '0);
  assign do_wr      = wr_en_q && !fifo_full;
  assign do_rd      = !fifo_empty && m_axis.tready;

  always_comb begin
    occ_d = occ_q;
    unique case ({do_wr, do_rd})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase
  end

  // NOTE: the storage array has no reset; emptiness is tracked by the pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem[wr_ptr_q] <= wr_word_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      space_ok_q <= 1'b0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (do_wr) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      occ_q      <= occ_d;
      space_ok_q <= (OCC_FULL - occ_q) >= SPACE_MIN;
      // A new flag event outranks a same-cycle clear.
      overflow_q <= (wr_en_q && fifo_full) || (overflow_q && !clear_i);
      err_q      <= frame_err || (err_q && !clear_i);
    end
  end

  // First-word-fall-through: the head entry is presented whenever the FIFO holds data.
  assign head = mem[rd_ptr_q];

  assign m_axis.tvalid = !fifo_empty;
  assign m_axis.tdata  = fifo_empty ? '0 : head.data;
  assign m_axis.tlast  = !fifo_empty && head.last;
  assign m_axis.tuser  = fifo_empty ? 2'b00 : {head.err, head.hdr};

  assign space_ok_o = space_ok_q;
  assign overflow_o = overflow_q;
  assign err_o      = err_q;

endmodule
